// File: rtl/prog_loader_if.sv
// rtl/prog_loader_if.sv - host byte streams (program in, data-memory dump out) for prog_loader
interface prog_loader_if;
   logic       in_valid;
   logic [7:0] in_data;
   logic       in_last;
   logic       in_ready;
   logic       out_valid;
   logic [7:0] out_data;
   logic       out_ready;

   // host side: sends program bytes, receives dump bytes
   modport master (
      output in_valid, in_data, in_last, out_ready,
      input  in_ready, out_valid, out_data
   );

   // loader side
   modport slave (
      input  in_valid, in_data, in_last, out_ready,
      output in_ready, out_valid, out_data
   );
endinterface

// File: rtl/prog_loader.sv
// rtl/prog_loader.sv - program loader and data-memory dumper; PROG_LOADER_CSUM_EN adds a trailing XOR checksum byte
module prog_loader #(
   parameter int D        = 12,
   parameter int DUMP_LEN = 256
) (
   input  logic         clk,
   input  logic         reset,
   prog_loader_if.slave host,
   output logic         im_we,
   output logic [D-1:0] im_addr,
   output logic [8:0]   im_dat,
   output logic         core_reset,
   input  logic         core_done,
   output logic [7:0]   dm_rd_addr,
   input  logic [7:0]   dm_rd_dat,
   output logic         busy
);

   typedef enum logic [2:0] {
      IDLE, LOAD_LO, LOAD_HI, RUN, DUMP_RD, DUMP_TX, CSUM
   } state_t;

   localparam logic [7:0] LAST_IDX = 8'(DUMP_LEN - 1);

   state_t       state_q, state_d;
   logic [D-1:0] addr_q, addr_d;
   logic [7:0]   lo_q, lo_d;
   logic [7:0]   idx_q, idx_d;
   logic [7:0]   hold_q, hold_d;
   logic         held_q, held_d;
`ifdef PROG_LOADER_CSUM_EN
   logic [7:0]   csum_q, csum_d;
`endif

   logic         in_rdy;
   logic         wr;
   logic [8:0]   wdat;
   logic [D-1:0] waddr;
   logic         o_valid;
   logic [7:0]   o_data;

   // state register and datapath registers; reset abandons any load or dump in progress
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= IDLE;
         addr_q  <= '0;
         lo_q    <= '0;
         idx_q   <= '0;
         hold_q  <= '0;
         held_q  <= 1'b0;
`ifdef PROG_LOADER_CSUM_EN
         csum_q  <= '0;
`endif
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         lo_q    <= lo_d;
         idx_q   <= idx_d;
         hold_q  <= hold_d;
         held_q  <= held_d;
`ifdef PROG_LOADER_CSUM_EN
         csum_q  <= csum_d;
`endif
      end
   end

   // next-state and handshake decode; the first DUMP_TX cycle forwards read data straight
   // through so a byte can leave every two cycles, later stalled cycles replay the held copy
   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      lo_d    = lo_q;
      idx_d   = idx_q;
      hold_d  = hold_q;
      held_d  = 1'b0;
`ifdef PROG_LOADER_CSUM_EN
      csum_d  = csum_q;
`endif
      in_rdy  = 1'b0;
      wr      = 1'b0;
      wdat    = '0;
      waddr   = addr_q;
      o_valid = 1'b0;
      o_data  = '0;
      case (state_q)
         IDLE: begin
            in_rdy = 1'b1;
            waddr  = '0;
            if (host.in_valid) begin
               if (host.in_last) begin
                  wr      = 1'b1;
                  wdat    = {1'b0, host.in_data};
                  addr_d  = D'(1);
                  state_d = RUN;
               end else begin
                  addr_d  = '0;
                  lo_d    = host.in_data;
                  state_d = LOAD_HI;
               end
            end
         end
         LOAD_LO: begin
            in_rdy = 1'b1;
            if (host.in_valid) begin
               if (host.in_last) begin
                  wr      = 1'b1;
                  wdat    = {1'b0, host.in_data};
                  addr_d  = addr_q + D'(1);
                  state_d = RUN;
               end else begin
                  lo_d    = host.in_data;
                  state_d = LOAD_HI;
               end
            end
         end
         LOAD_HI: begin
            in_rdy = 1'b1;
            if (host.in_valid) begin
               wr      = 1'b1;
               wdat    = {host.in_data[0], lo_q};
               addr_d  = addr_q + D'(1);
               state_d = host.in_last ? RUN : LOAD_LO;
            end
         end
         RUN: begin
            if (core_done) begin
               idx_d   = '0;
`ifdef PROG_LOADER_CSUM_EN
               csum_d  = '0;
`endif
               state_d = DUMP_RD;
            end
         end
         DUMP_RD: begin
            state_d = DUMP_TX;
         end
         DUMP_TX: begin
            o_valid = 1'b1;
            o_data  = held_q ? hold_q : dm_rd_dat;
            if (host.out_ready) begin
               idx_d = idx_q + 8'd1;
`ifdef PROG_LOADER_CSUM_EN
               csum_d = csum_q ^ o_data;
               state_d = (idx_q == LAST_IDX) ? CSUM : DUMP_RD;
`else
               state_d = (idx_q == LAST_IDX) ? IDLE : DUMP_RD;
`endif
            end else begin
               held_d = 1'b1;
               hold_d = o_data;
            end
         end
         CSUM: begin
`ifdef PROG_LOADER_CSUM_EN
            o_valid = 1'b1;
            o_data  = csum_q;
            if (host.out_ready) state_d = IDLE;
`else
            state_d = IDLE;
`endif
         end
         default: state_d = IDLE;
      endcase
   end

   // write pulse is masked by reset so a byte presented while reset is low never writes
   assign im_we         = wr & reset;
   assign im_addr       = waddr;
   assign im_dat        = im_we ? wdat : 9'd0;
   assign core_reset    = (state_q != RUN);
   assign busy          = (state_q != IDLE);
   assign dm_rd_addr    = idx_q;
   assign host.in_ready = in_rdy;
   assign host.out_valid = o_valid;
   assign host.out_data = o_data;

endmodule

// File: tb/tb_prog_loader.sv
// tb/tb_prog_loader.sv - randomized self-checking bench for prog_loader
module tb_prog_loader;
   localparam int D        = 4;
   localparam int DUMP_LEN = 4;
`ifdef PROG_LOADER_CSUM_EN
   localparam int N_OUT = DUMP_LEN + 1;
`else
   localparam int N_OUT = DUMP_LEN;
`endif

   logic         clk = 1'b0;
   logic         reset = 1'b0;
   logic         im_we;
   logic [D-1:0] im_addr;
   logic [8:0]   im_dat;
   logic         core_reset;
   logic         core_done = 1'b0;
   logic [7:0]   dm_rd_addr;
   logic [7:0]   dm_rd_dat = 8'h00;
   logic         busy;
   int           checks = 0;
   int           failures = 0;
   int           cyc = 0;

   logic [7:0]   mem [256];
   logic [D-1:0] wr_addr_q [$];
   logic [8:0]   wr_dat_q [$];
   logic         wr_cr_q [$];
   logic [7:0]   out_q [$];
   int           out_cyc_q [$];
   logic [7:0]   stim_q [$];
   logic [D-1:0] exp_addr [$];
   logic [8:0]   exp_dat [$];

   prog_loader_if bus ();

   prog_loader #(.D(D), .DUMP_LEN(DUMP_LEN)) dut (
      .clk        (clk),
      .reset      (reset),
      .host       (bus),
      .im_we      (im_we),
      .im_addr    (im_addr),
      .im_dat     (im_dat),
      .core_reset (core_reset),
      .core_done  (core_done),
      .dm_rd_addr (dm_rd_addr),
      .dm_rd_dat  (dm_rd_dat),
      .busy       (busy)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;
   always @(posedge clk) dm_rd_dat <= mem[dm_rd_addr];

   always @(negedge clk) begin
      if (im_we) begin
         wr_addr_q.push_back(im_addr);
         wr_dat_q.push_back(im_dat);
         wr_cr_q.push_back(core_reset);
      end
      if (bus.out_valid && bus.out_ready) begin
         out_q.push_back(bus.out_data);
         out_cyc_q.push_back(cyc);
      end
   end

   function automatic logic [7:0] exp_out(int i);
      logic [7:0] x = 8'h00;
      if (i < DUMP_LEN) return mem[i];
      for (int k = 0; k < DUMP_LEN; k++) x = x ^ mem[k];
      return x;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_q();
      wr_addr_q.delete(); wr_dat_q.delete(); wr_cr_q.delete();
      out_q.delete(); out_cyc_q.delete();
   endtask

   task automatic do_reset();
      @(posedge clk);
      #3;
      reset = 1'b0;
      bus.in_valid = 1'b0; bus.in_last = 1'b0; bus.out_ready = 1'b0; core_done = 1'b0;
      @(posedge clk);
      #1;
      reset = 1'b1;
      clear_q();
   endtask

   task automatic send_byte(input logic [7:0] b, input logic last);
      bus.in_valid = 1'b1; bus.in_data = b; bus.in_last = last;
      for (int n = 0; n < 50; n++) begin
         @(negedge clk);
         if (bus.in_ready) begin
            tick();
            bus.in_valid = 1'b0; bus.in_last = 1'b0;
            return;
         end
         tick();
      end
      checks++; failures++;
      $display("FAIL send_timeout: in_ready=%0b required 1", bus.in_ready);
      bus.in_valid = 1'b0; bus.in_last = 1'b0;
   endtask

   task automatic send_stream(input int gap_max);
      for (int i = 0; i < stim_q.size(); i++) begin
         int gap = $urandom_range(0, gap_max);
         repeat (gap) tick();
         send_byte(stim_q[i], i == stim_q.size() - 1);
      end
   endtask

   task automatic pulse_done();
      core_done = 1'b1;
      tick();
      core_done = 1'b0;
   endtask

   task automatic wait_idle();
      for (int n = 0; n < 400; n++) begin
         @(negedge clk);
         if (!busy) return;
      end
      checks++; failures++;
      $display("FAIL idle_timeout: busy=%0b required 0", busy);
   endtask

   task automatic wait_out_valid();
      for (int n = 0; n < 100; n++) begin
         @(negedge clk);
         if (bus.out_valid) return;
      end
      checks++; failures++;
      $display("FAIL out_valid_timeout: out_valid=%0b required 1", bus.out_valid);
   endtask

   task automatic test_reset();
      logic [4:0]  ctl;
      logic [28:0] dat;
      bus.in_valid = 1'b1; bus.in_data = 8'hFF; bus.in_last = 1'b1; bus.out_ready = 1'b1;
      #2;
      ctl = {bus.in_ready, im_we, core_reset, bus.out_valid, busy};
      dat = {im_addr, im_dat, dm_rd_addr, bus.out_data};
      checks++;
      if (ctl !== 5'b10100) begin
         failures++;
         $display("FAIL reset_ctl: got %b required 10100 (in_ready,im_we,core_reset,out_valid,busy)", ctl);
      end
      checks++;
      if (dat !== 29'd0) begin
         failures++;
         $display("FAIL reset_buses: got %h required 0", dat);
      end
      bus.in_valid = 1'b0; bus.in_last = 1'b0; bus.out_ready = 1'b0;
      tick();
      reset = 1'b1;
      clear_q();
   endtask

   task automatic test_load_basic();
      do_reset();
      stim_q = '{8'h12, 8'h01, 8'h34, 8'h00};
      send_stream(0);
      checks++;
      if (wr_dat_q.size() !== 2) begin
         failures++;
         $display("FAIL basic_count: got %0d writes required 2", wr_dat_q.size());
      end else begin
         checks++;
         if ({wr_addr_q[0], wr_dat_q[0], wr_addr_q[1], wr_dat_q[1]} !== {4'd0, 9'h112, 4'd1, 9'h034}) begin
            failures++;
            $display("FAIL basic_writes: got %0h:%h %0h:%h required 0:112 1:034",
                     wr_addr_q[0], wr_dat_q[0], wr_addr_q[1], wr_dat_q[1]);
         end
         checks++;
         if (wr_cr_q[1] !== 1'b1 || core_reset !== 1'b0) begin
            failures++;
            $display("FAIL basic_core_reset: at write %b after %b required 1 then 0", wr_cr_q[1], core_reset);
         end
      end
   endtask

   task automatic test_single();
      do_reset();
      stim_q = '{8'h7F};
      send_stream(0);
      checks++;
      if (wr_dat_q.size() !== 1 || wr_addr_q[0] !== 4'd0 || wr_dat_q[0] !== 9'h07F) begin
         failures++;
         $display("FAIL single_write: got %0d writes first %h required 1 write 0:07F", wr_dat_q.size(),
                  (wr_dat_q.size() > 0) ? wr_dat_q[0] : 9'h1FF);
      end
      checks++;
      if ({bus.in_ready, core_reset, busy} !== 3'b001) begin
         failures++;
         $display("FAIL single_run: in_ready,core_reset,busy=%b required 001", {bus.in_ready, core_reset, busy});
      end
   endtask

   task automatic test_done_in_load();
      do_reset();
      send_byte(8'h55, 1'b0);
      core_done = 1'b1;
      repeat (3) tick();
      @(negedge clk);
      checks++;
      if ({bus.in_ready, core_reset, busy} !== 3'b111) begin
         failures++;
         $display("FAIL done_in_load_state: in_ready,core_reset,busy=%b required 111", {bus.in_ready, core_reset, busy});
      end
      tick();
      core_done = 1'b0;
      send_byte(8'h01, 1'b1);
      checks++;
      if (wr_dat_q.size() !== 1 || wr_dat_q[0] !== 9'h155 || core_reset !== 1'b0) begin
         failures++;
         $display("FAIL done_in_load_write: got %0d writes core_reset=%b required 1 write 155 core_reset=0",
                  wr_dat_q.size(), core_reset);
      end
   endtask

   task automatic test_dump_fixed();
      logic [7:0] want [5];
      want = '{8'hA1, 8'hB2, 8'hC3, 8'hD4, 8'h04};
      do_reset();
      send_byte(8'h00, 1'b1);
      mem[0] = 8'hA1; mem[1] = 8'hB2; mem[2] = 8'hC3; mem[3] = 8'hD4;
      bus.out_ready = 1'b1;
      pulse_done();
      wait_idle();
      checks++;
      if (out_q.size() !== N_OUT) begin
         failures++;
         $display("FAIL dump_fixed_count: got %0d bytes required %0d", out_q.size(), N_OUT);
      end else begin
         for (int i = 0; i < N_OUT; i++) begin
            checks++;
            if (out_q[i] !== want[i]) begin
               failures++;
               $display("FAIL dump_fixed_byte%0d: got %h required %h", i, out_q[i], want[i]);
            end
         end
         for (int i = 1; i < N_OUT; i++) begin
            checks++;
            if (out_cyc_q[i] - out_cyc_q[i-1] > 2) begin
               failures++;
               $display("FAIL dump_throughput%0d: gap %0d cycles required <=2", i, out_cyc_q[i] - out_cyc_q[i-1]);
            end
         end
      end
      checks++;
      if (busy !== 1'b0) begin
         failures++;
         $display("FAIL dump_fixed_busy: got %b required 0", busy);
      end
      tick();
      bus.out_ready = 1'b0;
   endtask

   task automatic test_backpressure();
      do_reset();
      send_byte(8'h00, 1'b1);
      for (int i = 0; i < DUMP_LEN; i++) mem[i] = 8'($urandom);
      bus.out_ready = 1'b0;
      pulse_done();
      wait_out_valid();
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         checks++;
         if (bus.out_valid !== 1'b1 || bus.out_data !== mem[0]) begin
            failures++;
            $display("FAIL stall_hold%0d: valid=%b data=%h required 1 %h", k, bus.out_valid, bus.out_data, mem[0]);
         end
      end
      tick();
      bus.out_ready = 1'b1;
      wait_idle();
      checks++;
      if (out_q.size() !== N_OUT) begin
         failures++;
         $display("FAIL stall_count: got %0d bytes required %0d", out_q.size(), N_OUT);
      end else begin
         for (int i = 0; i < N_OUT; i++) begin
            checks++;
            if (out_q[i] !== exp_out(i)) begin
               failures++;
               $display("FAIL stall_byte%0d: got %h required %h", i, out_q[i], exp_out(i));
            end
         end
      end
      tick();
      bus.out_ready = 1'b0;
   endtask

   task automatic test_random();
      for (int it = 0; it < 6; it++) begin
         int n = $urandom_range(1, 40);
         int i = 0;
         int w = 0;
         logic       prev_stall = 1'b0;
         logic [7:0] prev_data = 8'h00;
         logic       done = 1'b0;
         do_reset();
         stim_q.delete(); exp_addr.delete(); exp_dat.delete();
         for (int k = 0; k < n; k++) stim_q.push_back(8'($urandom));
         while (i < n) begin
            exp_addr.push_back(D'(w % (1 << D)));
            if (i == n - 1) exp_dat.push_back({1'b0, stim_q[i]});
            else            exp_dat.push_back({stim_q[i+1][0], stim_q[i]});
            i += 2;
            w++;
         end
         send_stream(2);
         checks++;
         if (wr_dat_q.size() !== exp_dat.size()) begin
            failures++;
            $display("FAIL rand%0d_count: got %0d writes required %0d", it, wr_dat_q.size(), exp_dat.size());
         end else begin
            for (int k = 0; k < exp_dat.size(); k++) begin
               checks++;
               if (wr_addr_q[k] !== exp_addr[k] || wr_dat_q[k] !== exp_dat[k]) begin
                  failures++;
                  $display("FAIL rand%0d_write%0d: got %0h:%h required %0h:%h", it, k,
                           wr_addr_q[k], wr_dat_q[k], exp_addr[k], exp_dat[k]);
               end
            end
         end
         for (int k = 0; k < DUMP_LEN; k++) mem[k] = 8'($urandom);
         bus.out_ready = 1'b0;
         pulse_done();
         for (int k = 0; k < 400 && !done; k++) begin
            @(negedge clk);
            if (prev_stall) begin
               checks++;
               if (bus.out_valid !== 1'b1 || bus.out_data !== prev_data) begin
                  failures++;
                  $display("FAIL rand%0d_stable: valid=%b data=%h required 1 %h", it, bus.out_valid, bus.out_data, prev_data);
               end
            end
            if (!busy) done = 1'b1;
            prev_stall = bus.out_valid && !bus.out_ready;
            prev_data  = bus.out_data;
            tick();
            bus.out_ready = 1'($urandom_range(0, 1));
         end
         checks++;
         if (!done || out_q.size() !== N_OUT) begin
            failures++;
            $display("FAIL rand%0d_dump_count: got %0d bytes done=%b required %0d", it, out_q.size(), done, N_OUT);
         end else begin
            for (int k = 0; k < N_OUT; k++) begin
               checks++;
               if (out_q[k] !== exp_out(k)) begin
                  failures++;
                  $display("FAIL rand%0d_byte%0d: got %h required %h", it, k, out_q[k], exp_out(k));
               end
            end
         end
         bus.out_ready = 1'b0;
      end
   endtask

   task automatic test_reset_mid_dump();
      do_reset();
      send_byte(8'h00, 1'b1);
      bus.out_ready = 1'b0;
      pulse_done();
      wait_out_valid();
      @(posedge clk);
      #3;
      reset = 1'b0;
      #1;
      checks++;
      if ({bus.out_valid, core_reset, busy, bus.in_ready} !== 4'b0101 || dm_rd_addr !== 8'd0) begin
         failures++;
         $display("FAIL midreset_outputs: out_valid,core_reset,busy,in_ready=%b rd_addr=%h required 0101 00",
                  {bus.out_valid, core_reset, busy, bus.in_ready}, dm_rd_addr);
      end
      tick();
      reset = 1'b1;
      clear_q();
      stim_q = '{8'h21, 8'h01, 8'h43, 8'h00};
      send_stream(1);
      checks++;
      if (wr_dat_q.size() !== 2 || wr_addr_q[0] !== 4'd0 || wr_dat_q[0] !== 9'h121 ||
          wr_addr_q[1] !== 4'd1 || wr_dat_q[1] !== 9'h043) begin
         failures++;
         $display("FAIL midreset_reload: got %0d writes, first addr %0h required 2 writes 0:121 1:043",
                  wr_dat_q.size(), (wr_addr_q.size() > 0) ? wr_addr_q[0] : 4'hF);
      end
   endtask

   initial begin
      bus.in_valid = 1'b0; bus.in_data = 8'h00; bus.in_last = 1'b0; bus.out_ready = 1'b0;
      for (int i = 0; i < 256; i++) mem[i] = 8'h00;
      #12;
      test_reset();
      test_load_basic();
      test_single();
      test_done_in_load();
      test_dump_fixed();
      test_backpressure();
      test_random();
      test_reset_mid_dump();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/prog_loader.md
PROG_LOADER -- requirements
Module: prog_loader

Interface
REQ-001 SHALL have parameter D, default 12, instruction-memory address width (matches program counter width).
REQ-002 SHALL have parameter DUMP_LEN, default 256, number of data-memory bytes read back after a run (1..256).
REQ-003 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset (asserted at 0).
REQ-005 SHALL have ports in_valid input 1, in_data input 8, in_last input 1, in_ready output 1: host byte stream in.
REQ-006 SHALL have ports im_we output 1, im_addr output D, im_dat output 9: instruction-memory write port.
REQ-007 SHALL have ports core_reset output 1 (active-high, holds processor in reset) and core_done input 1 (processor done flag).
REQ-008 SHALL have ports dm_rd_addr output 8 and dm_rd_dat input 8: data-memory read port, read data valid one cycle after address.
REQ-009 SHALL have ports out_valid output 1, out_data output 8, out_ready input 1: host byte stream out.
REQ-010 SHALL have port busy output 1, high in every state except IDLE.

Function
REQ-011 SHALL implement states IDLE, LOAD_LO, LOAD_HI, RUN, DUMP_RD, DUMP_TX, CSUM, with IDLE as reset state.
REQ-012 Byte transfer on in_valid & in_ready; out transfer on out_valid & out_ready; no other event consumes or produces a byte.
REQ-013 IDLE: in_ready=1, core_reset=1; first accepted byte SHALL be the low byte of instruction 0, latched, state -> LOAD_HI, write address cleared to 0.
REQ-014 LOAD_LO: in_ready=1; accepted byte latched as im_dat[7:0], -> LOAD_HI.
REQ-015 LOAD_HI: in_ready=1; on accept, im_we=1 for exactly that cycle with im_dat={in_data[0], latched low byte}, im_addr=current address; address then increments by 1; -> LOAD_LO, or -> RUN if in_last=1.
REQ-016 in_last on a low byte SHALL write that instruction with bit 8=0 in the same cycle and -> RUN.
REQ-017 Address wrap from 2^D-1 to 0 SHALL occur silently; later words overwrite earlier ones.
REQ-018 core_reset SHALL be 1 in every state except RUN; in RUN it SHALL be 0 from the first cycle after entry.
REQ-019 RUN: in_ready=0; core_done sampled high -> DUMP_RD with read address 0 and checksum cleared; core_done is ignored in all other states.
REQ-020 DUMP_RD: drive dm_rd_addr=index for one cycle, -> DUMP_TX; DUMP_TX registers dm_rd_dat into out_data and asserts out_valid.
REQ-021 out_data SHALL stay stable while out_valid=1 and out_ready=0.
REQ-022 On out transfer: index increments; index==DUMP_LEN-1 -> CSUM (if enabled) else IDLE; otherwise -> DUMP_RD.
REQ-023 Back-to-back throughput SHALL be one byte per 2 cycles minimum with out_ready held high.
REQ-024 in_ready SHALL be 0 in RUN, DUMP_RD, DUMP_TX, CSUM; host bytes there are not accepted.

Reset
REQ-025 reset=0 SHALL immediately force IDLE, in_ready=1, im_we=0, im_addr=0, im_dat=0, core_reset=1, dm_rd_addr=0, out_valid=0, out_data=0, busy=0, independent of clk.
REQ-026 Reset mid-load or mid-dump SHALL abandon the transfer; no partial write pulse or out_valid SHALL survive reset assertion.
REQ-027 Release of reset SHALL take effect on the first rising clk edge after reset=1.

Configuration
REQ-028 Macro PROG_LOADER_CSUM_EN defined: each dumped byte XORed into an 8-bit checksum; after the last byte, CSUM state presents checksum on out_data with out_valid until accepted, then -> IDLE.
REQ-029 Macro PROG_LOADER_CSUM_EN undefined: no checksum register, CSUM state unreachable, dump ends after DUMP_LEN bytes.

Verification
REQ-030 Bytes 0x12,0x01,0x34,0x00(last) -> im_we pulses: addr 0 dat 0x112, addr 1 dat 0x034; core_reset falls one cycle after second write.
REQ-031 Single byte 0x7F with in_last -> one write addr 0 dat 0x07F, then RUN.
REQ-032 core_done=1 in RUN, DUMP_LEN=4, memory 0xA1,0xB2,0xC3,0xD4, out_ready=1 -> out bytes A1,B2,C3,D4 (plus checksum 0x04 with PROG_LOADER_CSUM_EN), then busy=0.
REQ-033 out_ready held 0 for 5 cycles during dump -> out_data and out_valid unchanged all 5 cycles, no byte lost or duplicated.
REQ-034 reset=0 asserted mid-dump (between clk edges) -> out_valid=0, core_reset=1, busy=0 immediately; next load restarts at address 0.
REQ-035 core_done=1 during LOAD_HI -> ignored, loading continues and RUN entered normally.
